core_seq: RTL and testbench

//   Multi-cycle sequencer for the RV32 core. Fetches each instruction over a valid/ready handshake and holds it in an

---
 rtl/core_seq_pkg.sv | 44 ++++
 rtl/core_seq_timer.sv | 30 +++
 rtl/core_seq.sv | 129 ++++++++++++
 tb/tb_core_seq.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared constants and types for the multi-cycle sequencer and its neighbours.
package core_seq_pkg;

  localparam int unsigned SEQ_STATE_WIDTH = 4;

  typedef enum logic [SEQ_STATE_WIDTH-1:0] {
    StFetchReq  = 4'd0,
    StFetchWait = 4'd1,
    StDecode    = 4'd2,
    StExec      = 4'd3,
    StMemReq    = 4'd4,
    StMemWait   = 4'd5,
    StWb        = 4'd6,
    StHalt      = 4'd7,
    StErr       = 4'd8
  } seq_state_e;

  // RV32I major opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  // True for every opcode the core implements.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_SYSTEM: legal = 1'b1;
      default:                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/core_seq_timer.sv
// Bus wait-state watchdog: 8-bit clear/enable counter with terminal count.
module seq_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  // tc marks the TIMEOUT-th waiting cycle, so the owner leaves on the edge that ends it.
  localparam logic [7:0] TcCount = 8'(TIMEOUT - 1);

  logic [7:0] count_q;

  // Count waiting cycles; clear has priority over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 8'd0;
    end else if (clr) begin
      count_q <= 8'd0;
    end else if (en) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign tc = en && (count_q == TcCount);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle RV32 sequencer: fetch, decode, execute, memory, writeback.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_valid,
  input  logic        ifu_req_ready,
  input  logic        ifu_resp_valid,
  input  logic [31:0] ifu_resp_inst,
  output logic [31:0] inst,
  output logic        lsu_req_valid,
  output logic        lsu_req_wen,
  input  logic        lsu_req_ready,
  input  logic        lsu_resp_valid,
  output logic        gpr_w_en,
  output logic        pc_w_en,
  output logic        halt,
  output logic        err,
  output logic [63:0] instret
);

  seq_state_e  state_q, state_d;
  logic [31:0] inst_q;
  logic        halt_q, err_q;
  logic [63:0] instret_q;

  logic [6:0]  opcode;
  logic        is_load, is_store, is_branch, is_ebreak;
  logic        timer_clr, timer_en, timer_tc;

  assign opcode    = inst_q[6:0];
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_ebreak = (inst_q == INST_EBREAK);

  // Timer restarts on each accepted request and runs only in the WAIT states.
  assign timer_clr = ((state_q == StFetchReq) && ifu_req_ready) ||
                     ((state_q == StMemReq) && lsu_req_ready);
  assign timer_en  = (state_q == StFetchWait) || (state_q == StMemWait);

  seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  // Next-state decode; a response on the terminal-count cycle beats the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetchReq:  if (ifu_req_ready) state_d = StFetchWait;
      StFetchWait: begin
        if (ifu_resp_valid)  state_d = StDecode;
        else if (timer_tc)   state_d = StErr;
      end
      StDecode:    state_d = is_legal_op(opcode) ? StExec : StErr;
      StExec:      state_d = (is_load || is_store) ? StMemReq : StWb;
      StMemReq:    if (lsu_req_ready) state_d = StMemWait;
      StMemWait: begin
        if (lsu_resp_valid)  state_d = StWb;
        else if (timer_tc)   state_d = StErr;
      end
      StWb:        state_d = is_ebreak ? StHalt : StFetchReq;
      StHalt:      state_d = StHalt;
      StErr:       state_d = StErr;
      default:     state_d = StErr;
    endcase
  end

  // State, instruction register, sticky flags and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetchReq;
      inst_q    <= INST_NOP;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == StFetchWait) && ifu_resp_valid) begin
        inst_q <= ifu_resp_inst;
      end
      if ((state_d == StErr) && (state_q != StErr)) begin
        err_q <= 1'b1;
      end
      if (state_q == StWb) begin
        instret_q <= instret_q + 64'd1;
        if (is_ebreak) begin
          halt_q <= 1'b1;
        end
      end
    end
  end

  // Moore strobes: decoded from the current state only.
  always_comb begin
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    lsu_req_wen   = 1'b0;
    gpr_w_en      = 1'b0;
    pc_w_en       = 1'b0;
    unique case (state_q)
      StFetchReq: ifu_req_valid = 1'b1;
      StMemReq: begin
        lsu_req_valid = 1'b1;
        lsu_req_wen   = is_store;
      end
      StWb: begin
        pc_w_en  = 1'b1;
        gpr_w_en = !(is_branch || is_store);
      end
      default: ;
    endcase
  end

  assign inst    = inst_q;
  assign halt    = halt_q;
  assign err     = err_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Directed bench for core_seq with a small zero/variable-wait bus responder.
module tb_core_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid;
  logic        ifu_req_ready = 1'b0;
  logic        ifu_resp_valid = 1'b0;
  logic [31:0] ifu_resp_inst = 32'h0;
  logic [31:0] inst;
  logic        lsu_req_valid;
  logic        lsu_req_wen;
  logic        lsu_req_ready = 1'b0;
  logic        lsu_resp_valid = 1'b0;
  logic        gpr_w_en;
  logic        pc_w_en;
  logic        halt;
  logic        err;
  logic [63:0] instret;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_seq #(
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_inst  (ifu_resp_inst),
    .inst           (inst),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_wen    (lsu_req_wen),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_resp_valid (lsu_resp_valid),
    .gpr_w_en       (gpr_w_en),
    .pc_w_en        (pc_w_en),
    .halt           (halt),
    .err            (err),
    .instret        (instret)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_req_ready  = 1'b0;
    lsu_resp_valid = 1'b0;
  endtask

  // Enter with rst=1 asserted; leave in FETCH_REQ with rst low for the next cycle.
  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH_REQ. Fetch answers immediately; lsu_req_ready rises after
  // lsu_delay stalled request cycles. Cycle 1 is the first FETCH_REQ cycle.
  task automatic run_one(input logic [31:0] word, input int lsu_delay, output int cyc,
                         output int n_gpr, output int n_pc, output int n_lsu,
                         output logic wen_seen);
    logic ifu_pend, lsu_pend, ifu_pend_n, lsu_pend_n, pc_seen, done;
    int   c;
    cyc = 0; n_gpr = 0; n_pc = 0; n_lsu = 0; wen_seen = 1'b0;
    ifu_pend = 1'b0; lsu_pend = 1'b0; pc_seen = 1'b0; done = 1'b0;
    c = 1;
    while (!done && c <= 40) begin
      ifu_req_ready  = ifu_req_valid;
      ifu_resp_valid = ifu_pend;
      ifu_resp_inst  = word;
      if (lsu_req_valid) begin
        n_lsu++;
        if (lsu_req_wen) wen_seen = 1'b1;
        lsu_req_ready = (n_lsu > lsu_delay);
      end else begin
        lsu_req_ready = 1'b0;
      end
      lsu_resp_valid = lsu_pend;
      if (gpr_w_en) n_gpr++;
      if (pc_w_en) begin
        n_pc++;
        cyc = c;
        pc_seen = 1'b1;
      end
      ifu_pend_n = ifu_req_valid && ifu_req_ready;
      lsu_pend_n = lsu_req_valid && lsu_req_ready;
      step();
      c++;
      ifu_pend = ifu_pend_n;
      lsu_pend = lsu_pend_n;
      done = pc_seen || err;
    end
    idle_inputs();
  endtask

  int   cyc, n_gpr, n_pc, n_lsu, k, n_strobe;
  logic wen;

  initial begin
    // Reset values while rst is still held
    step();
    step();
    check_eq("rst_inst", inst, 64'h13);
    check_eq("rst_instret", instret, 64'd0);
    check_eq("rst_flags", {halt, err, gpr_w_en, pc_w_en, lsu_req_valid}, 64'd0);
    check_eq("rst_fetch_valid", ifu_req_valid, 64'd1);
    rst = 1'b0;

    // addi: 5 cycles, both strobes once
    run_one(32'h0050_0093, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("addi_cycle", cyc, 64'd5);
    check_eq("addi_gpr", n_gpr, 64'd1);
    check_eq("addi_pc", n_pc, 64'd1);
    check_eq("addi_instret", instret, 64'd1);
    check_eq("addi_ir", inst, 64'h0050_0093);

    // load with 3 stalled request cycles: 10 cycles
    run_one(32'h0001_2083, 3, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("load_cycle", cyc, 64'd10);
    check_eq("load_req_cycles", n_lsu, 64'd4);
    check_eq("load_wen", wen, 64'd0);
    check_eq("load_gpr", n_gpr, 64'd1);

    // store: zero-wait, 7 cycles
    run_one(32'h0011_2023, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("store_cycle", cyc, 64'd7);
    check_eq("store_wen", wen, 64'd1);
    check_eq("store_gpr", n_gpr, 64'd0);
    check_eq("store_pc", n_pc, 64'd1);

    // branch
    run_one(32'h0000_0063, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("branch_cycle", cyc, 64'd5);
    check_eq("branch_gpr", n_gpr, 64'd0);
    check_eq("branch_pc", n_pc, 64'd1);

    // ecall retires as an ordinary I-type
    run_one(32'h0000_0073, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("ecall_gpr", n_gpr, 64'd1);
    check_eq("ecall_halt", halt, 64'd0);
    check_eq("ecall_instret", instret, 64'd5);

    // ebreak halts; bus activity afterwards produces no strobes
    run_one(32'h0010_0073, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("ebreak_pc", n_pc, 64'd1);
    check_eq("ebreak_halt", halt, 64'd1);
    check_eq("ebreak_instret", instret, 64'd6);
    ifu_req_ready = 1'b1; ifu_resp_valid = 1'b1; lsu_resp_valid = 1'b1; lsu_req_ready = 1'b1;
    n_strobe = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifu_req_valid || lsu_req_valid || gpr_w_en || pc_w_en) n_strobe++;
    end
    check_eq("halt_no_strobe", n_strobe, 64'd0);
    check_eq("halt_instret_frozen", instret, 64'd6);
    check_eq("halt_sticky", halt, 64'd1);
    do_reset();
    check_eq("halt_rst_flag", halt, 64'd0);
    check_eq("halt_rst_fetch", ifu_req_valid, 64'd1);
    check_eq("halt_rst_instret", instret, 64'd0);

    // illegal opcode
    run_one(32'h0000_0000, 0, cyc, n_gpr, n_pc, n_lsu, wen);
    check_eq("illegal_err", err, 64'd1);
    check_eq("illegal_strobes", n_gpr + n_pc, 64'd0);
    check_eq("illegal_instret", instret, 64'd0);
    do_reset();
    check_eq("illegal_rst_err", err, 64'd0);

    // fetch timeout: err exactly 4 cycles after entering FETCH_WAIT
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    k = 0;
    while (!err && k < 20) begin
      step();
      k++;
    end
    check_eq("timeout_cycles", k, 64'd4);
    check_eq("timeout_err", err, 64'd1);
    do_reset();

    // response on the terminal-count cycle wins
    ifu_req_ready = 1'b1;
    step();
    ifu_req_ready = 1'b0;
    repeat (3) step();
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = 32'h0050_0093;
    step();
    ifu_resp_valid = 1'b0;
    check_eq("tc_race_err", err, 64'd0);
    check_eq("tc_race_ir", inst, 64'h0050_0093);
    step();
    step();
    check_eq("tc_race_wb", pc_w_en, 64'd1);
    step();
    do_reset();

    // reset while in MEM_WAIT, then a stale load response
    ifu_req_ready = 1'b1;
    step();                                     // FETCH_WAIT
    ifu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b1;
    ifu_resp_inst  = 32'h0001_2083;
    step();                                     // DECODE
    ifu_resp_valid = 1'b0;
    step();                                     // EXEC
    step();                                     // MEM_REQ
    check_eq("mw_req", lsu_req_valid, 64'd1);
    lsu_req_ready = 1'b1;
    step();                                     // MEM_WAIT
    lsu_req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    lsu_resp_valid = 1'b1;
    n_strobe = 0;
    for (int i = 0; i < 3; i++) begin
      if (gpr_w_en || pc_w_en || lsu_req_valid) n_strobe++;
      step();
    end
    lsu_resp_valid = 1'b0;
    check_eq("mw_no_strobe", n_strobe, 64'd0);
    check_eq("mw_fetch", ifu_req_valid, 64'd1);
    check_eq("mw_instret", instret, 64'd0);
    check_eq("mw_ir", inst, 64'h13);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
